cdb_arbiter: RTL and testbench

- Shares the single Common Data Bus (CDB) between the functional-unit result producers: ALU, MUL/DIV, LSU and branch unit.
- Each FU holds `cdb_request` together with its tagged result. The arbiter grants one requester per cycle using round-robin priority.
- The granted result is registered and broadcast as the CDB (valid/tag/data) to the reservation stations, register status and ROB.

---
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: picks one tagged FU result per cycle and registers it as the CDB broadcast.
// Optional per-FU grant / conflict statistics are enabled by defining CDB_ARB_STATS_EN.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      cdb_hold,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic                      proto_err
`ifdef CDB_ARB_STATS_EN
    ,
    input  logic [1:0]                stat_sel,
    output logic [15:0]               stat_grant_cnt,
    output logic [15:0]               stat_conflict_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic               proto_err_q, proto_err_d;

    logic [NUM_REQ-1:0] elig;
    logic               proto_hit;
    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    logic [TAG_W-1:0]   gnt_tag;
    logic [DATA_W-1:0]  gnt_data;

    // Tag 0 means "no producer": such a request is never eligible and flags a protocol error.
    always_comb begin
        elig      = '0;
        proto_hit = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] && (req_tag[i*TAG_W +: TAG_W] != '0);
            if (req[i] && (req_tag[i*TAG_W +: TAG_W] == '0))
                proto_hit = 1'b1;
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        grant     = '0;
        if (!rst && !flush && !cdb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_found && elig[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                end
            end
        end
        if (gnt_found)
            grant[gnt_idx] = 1'b1;
    end

    always_comb begin
        gnt_tag  = req_tag[gnt_idx*TAG_W +: TAG_W];
        gnt_data = req_data[gnt_idx*DATA_W +: DATA_W];
    end

    // Idle cycles clear the tag but leave data as-is, so only valid/tag toggle on the bus.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = gnt_found;
        cdb_tag_d   = '0;
        cdb_data_d  = cdb_data_q;
        proto_err_d = proto_err_q | proto_hit;
        if (gnt_found) begin
            rr_ptr_d   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            cdb_tag_d  = gnt_tag;
            cdb_data_d = gnt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign proto_err = proto_err_q;

`ifdef CDB_ARB_STATS_EN
    logic [15:0]        grant_cnt_q [NUM_REQ];
    logic [15:0]        grant_cnt_d [NUM_REQ];
    logic [15:0]        conflict_cnt_q, conflict_cnt_d;
    logic               multi_elig;

    // Counters saturate at all-ones; flush deliberately leaves them alone.
    always_comb begin
        multi_elig     = |(elig & (elig - NUM_REQ'(1)));
        conflict_cnt_d = conflict_cnt_q;
        if (gnt_found && multi_elig && (conflict_cnt_q != 16'hFFFF))
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (grant[i] && (grant_cnt_q[i] != 16'hFFFF))
                grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                grant_cnt_q[i] <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            for (int i = 0; i < NUM_REQ; i++)
                grant_cnt_q[i] <= grant_cnt_d[i];
        end
    end

    assign stat_grant_cnt    = (int'(stat_sel) < NUM_REQ) ? grant_cnt_q[stat_sel] : '0;
    assign stat_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference model predicts grant and the next-cycle CDB word for every driven cycle.
// The statistics scenario is compiled only when CDB_ARB_STATS_EN is defined.
module tb_cdb_arbiter;

    typedef struct packed {
        logic        v;
        logic [7:0]  t;
        logic [31:0] d;
    } cdb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         cdb_hold = 1'b0;
    logic [3:0]   req = '0;
    logic [31:0]  req_tag = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   grant;
    logic         cdb_valid;
    logic [7:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         proto_err;
`ifdef CDB_ARB_STATS_EN
    logic [1:0]   stat_sel = '0;
    logic [15:0]  stat_grant_cnt;
    logic [15:0]  stat_conflict_cnt;
`endif

    int   total = 0;
    int   bad = 0;
    int   m_ptr = 0;
    logic [31:0] m_data = '0;
    cdb_t sb[$];

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cdb_hold(cdb_hold),
        .req(req), .req_tag(req_tag), .req_data(req_data), .grant(grant),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .proto_err(proto_err)
`ifdef CDB_ARB_STATS_EN
        , .stat_sel(stat_sel), .stat_grant_cnt(stat_grant_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drives one cycle, predicts grant and pushes the expected CDB word, then pops it after the edge.
    task automatic step(input logic [3:0] r, input logic [31:0] tags, input logic [127:0] datas,
                        input logic f, input logic h,
                        output logic [3:0] g_obs, output logic [3:0] g_exp,
                        output cdb_t c_obs, output cdb_t c_exp);
        int   gi;
        cdb_t e;
        req = r; req_tag = tags; req_data = datas; flush = f; cdb_hold = h;
        @(negedge clk);
        g_obs = grant;
        g_exp = '0;
        gi = -1;
        if (!f && !h) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (gi < 0 && r[idx] && tags[idx*8 +: 8] != 8'h00) gi = idx;
            end
        end
        if (gi >= 0) begin
            g_exp[gi] = 1'b1;
            e.v = 1'b1; e.t = tags[gi*8 +: 8]; e.d = datas[gi*32 +: 32];
            m_data = e.d;
            m_ptr = (gi + 1) % 4;
        end else begin
            e.v = 1'b0; e.t = 8'h00; e.d = m_data;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        c_obs = {cdb_valid, cdb_tag, cdb_data};
        c_exp = sb.pop_front();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_tag = '0; req_data = '0; flush = 1'b0; cdb_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; m_data = '0;
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; req_tag = 32'h44332211; req_data = '1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin bad++; $display("[TB] FAIL reset_grant got=%b want=0000", grant); end
        total++;
        if ({cdb_valid, cdb_tag, cdb_data, proto_err} !== 42'd0) begin
            bad++; $display("[TB] FAIL reset_outputs got v=%b t=%h d=%h pe=%b want all zero", cdb_valid, cdb_tag, cdb_data, proto_err);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [3:0] go, ge; cdb_t co, ce;
        step(4'b0100, 32'h0021_0000, {32'h0, 32'hDEADBEEF, 64'h0}, 1'b0, 1'b0, go, ge, co, ce);
        total++;
        if (go !== 4'b0100) begin bad++; $display("[TB] FAIL single_grant got=%b want=0100", go); end
        total++;
        if (co !== {1'b1, 8'h21, 32'hDEADBEEF}) begin bad++; $display("[TB] FAIL single_cdb got=%h want=%h", co, {1'b1, 8'h21, 32'hDEADBEEF}); end
        step(4'b0000, 32'h0, 128'h0, 1'b0, 1'b0, go, ge, co, ce);
        total++;
        if ({co.v, co.t} !== 9'h000) begin bad++; $display("[TB] FAIL single_idle got v=%b t=%h want v=0 t=00", co.v, co.t); end
        total++;
        if (co !== ce) begin bad++; $display("[TB] FAIL single_hold_data got=%h want=%h", co, ce); end
    endtask

    task automatic test_round_robin();
        logic [3:0] go, ge; cdb_t co, ce;
        logic [31:0] tags; logic [127:0] datas;
        // Grant FU3 once so the pointer starts at 0.
        step(4'b1000, 32'h0800_0000, {32'h0000_0088, 96'h0}, 1'b0, 1'b0, go, ge, co, ce);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 4; i++) begin
                tags[i*8 +: 8] = 8'(8'h10 + 8'(k*4 + i) + 8'h1);
                datas[i*32 +: 32] = 32'hA000_0000 + 32'(k*16 + i);
            end
            step(4'b1111, tags, datas, 1'b0, 1'b0, go, ge, co, ce);
            total++;
            if (go !== 4'(1 << (k % 4))) begin bad++; $display("[TB] FAIL rr_grant cycle=%0d got=%b want=%b", k, go, 4'(1 << (k % 4))); end
            total++;
            if (co !== ce) begin bad++; $display("[TB] FAIL rr_cdb cycle=%0d got=%h want=%h", k, co, ce); end
        end
        // FU2 once leaves the pointer at 3 for the wrap check.
        step(4'b0100, 32'h0055_0000, {32'h0, 32'h5555, 64'h0}, 1'b0, 1'b0, go, ge, co, ce);
        for (int k = 0; k < 3; k++) begin
            step(4'b1001, 32'h9900_0011, {32'h9999_0000 + 32'(k), 64'h0, 32'h1111_0000 + 32'(k)}, 1'b0, 1'b0, go, ge, co, ce);
            total++;
            if (go !== ((k == 1) ? 4'b0001 : 4'b1000)) begin bad++; $display("[TB] FAIL wrap_grant cycle=%0d got=%b", k, go); end
            total++;
            if (co !== ce) begin bad++; $display("[TB] FAIL wrap_cdb cycle=%0d got=%h want=%h", k, co, ce); end
        end
        step(4'b0000, 32'h0, 128'h0, 1'b0, 1'b0, go, ge, co, ce);
    endtask

    task automatic test_flush_hold();
        logic [3:0] go, ge; cdb_t co, ce;
        logic [4:0] seq_flush = 5'b00100, seq_hold = 5'b01000;
        logic [3:0] want [5] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100};
        logic [3:0] reqs [5] = '{4'b0010, 4'b0010, 4'b1111, 4'b1111, 4'b1111};
        seq_flush[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(reqs[k], 32'h4433_2211, {32'h4, 32'h3, 32'h2, 32'h1} + 128'(k), seq_flush[k], seq_hold[k], go, ge, co, ce);
            total++;
            if (go !== want[k]) begin bad++; $display("[TB] FAIL flush_hold_grant cycle=%0d got=%b want=%b", k, go, want[k]); end
            total++;
            if (co !== ce) begin bad++; $display("[TB] FAIL flush_hold_cdb cycle=%0d got=%h want=%h", k, co, ce); end
        end
        step(4'b0000, 32'h0, 128'h0, 1'b0, 1'b0, go, ge, co, ce);
    endtask

    task automatic test_proto_err();
        logic [3:0] go, ge; cdb_t co, ce;
        total++;
        if (proto_err !== 1'b0) begin bad++; $display("[TB] FAIL proto_initial got=%b want=0", proto_err); end
        step(4'b0110, 32'h0045_0000, {32'h0, 32'h4545, 32'h1234, 32'h0}, 1'b0, 1'b0, go, ge, co, ce);
        total++;
        if (go !== 4'b0100) begin bad++; $display("[TB] FAIL proto_grant got=%b want=0100", go); end
        total++;
        if (co !== ce) begin bad++; $display("[TB] FAIL proto_cdb got=%h want=%h", co, ce); end
        step(4'b0010, 32'h0, 128'h0, 1'b0, 1'b0, go, ge, co, ce);
        total++;
        if (go !== 4'b0000) begin bad++; $display("[TB] FAIL tag0_only_grant got=%b want=0000", go); end
        step(4'b0000, 32'h0, 128'h0, 1'b0, 1'b0, go, ge, co, ce);
        total++;
        if (proto_err !== 1'b1) begin bad++; $display("[TB] FAIL proto_sticky got=%b want=1", proto_err); end
        step(4'b0100, 32'h0046_0000, {32'h0, 32'h4646, 64'h0}, 1'b0, 1'b0, go, ge, co, ce);
        total++;
        if (co !== {1'b1, 8'h46, 32'h4646}) begin bad++; $display("[TB] FAIL pre_rst_cdb got=%h want=%h", co, {1'b1, 8'h46, 32'h4646}); end
        req = '0;
        rst = 1'b1;
        #1;
        total++;
        if ({cdb_valid, proto_err, grant} !== 6'b0) begin
            bad++; $display("[TB] FAIL async_rst got v=%b pe=%b g=%b want all zero", cdb_valid, proto_err, grant);
        end
        do_reset();
    endtask

`ifdef CDB_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req = 4'b0011; req_tag = 32'h0000_2211; req_data = '0;
        repeat (10) @(posedge clk);
        #1;
        req = 4'b0000;
        stat_sel = 2'd0;
        #1;
        total++;
        if (stat_grant_cnt !== 16'd5) begin bad++; $display("[TB] FAIL stat_fu0 got=%0d want=5", stat_grant_cnt); end
        stat_sel = 2'd1;
        #1;
        total++;
        if (stat_grant_cnt !== 16'd5) begin bad++; $display("[TB] FAIL stat_fu1 got=%0d want=5", stat_grant_cnt); end
        total++;
        if (stat_conflict_cnt !== 16'd10) begin bad++; $display("[TB] FAIL stat_conflict got=%0d want=10", stat_conflict_cnt); end
        req = 4'b0001;
        repeat (65535) @(posedge clk);
        #1;
        req = 4'b0000;
        stat_sel = 2'd0;
        #1;
        total++;
        if (stat_grant_cnt !== 16'hFFFF) begin bad++; $display("[TB] FAIL stat_saturate got=%h want=ffff", stat_grant_cnt); end
        total++;
        if (stat_conflict_cnt !== 16'd10) begin bad++; $display("[TB] FAIL stat_conflict_single got=%0d want=10", stat_conflict_cnt); end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_flush_hold();
        test_proto_err();
`ifdef CDB_ARB_STATS_EN
        test_stats();
`endif
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
